// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one command-driven RAM between two word-level requesters.
// Optional read-response watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_access_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [ADDR_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [ADDR_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [ADDR_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [ADDR_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH+1:0] ram_din,
   output logic                  ram_rx_valid,
   input  logic [ADDR_WIDTH-1:0] ram_dout,
   input  logic                  ram_tx_valid,
   output logic                  busy,
   output logic                  owner,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {
      StIdle, StWaddr, StWdata, StRaddr, StRcmd, StRwait, StAck
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   state_t                state;
   logic                  last;
   logic [ADDR_WIDTH-1:0] wdata_q;

   logic                  gnt;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [ADDR_WIDTH-1:0] sel_wdata;

   // Contention goes to the port that did not win last; a lone requester always wins.
   always_comb begin
      gnt       = (m0_req && m1_req) ? ~last : m1_req;
      sel_we    = gnt ? m1_we    : m0_we;
      sel_addr  = gnt ? m1_addr  : m0_addr;
      sel_wdata = gnt ? m1_wdata : m0_wdata;
   end

   assign busy = (state != StIdle);

`ifdef ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= StIdle;
         last         <= 1'b1;
         owner        <= 1'b0;
         wdata_q      <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         m0_ack       <= 1'b0;
         m1_ack       <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
`ifdef ARB_TIMEOUT_EN
         wait_cnt     <= '0;
         timeout_err  <= 1'b0;
`endif
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         // Outputs are loaded on the transition so they line up with the state they belong to.
         unique case (state)
            StIdle: begin
               if (m0_req || m1_req) begin
                  owner        <= gnt;
                  last         <= gnt;
                  wdata_q      <= sel_wdata;
                  ram_rx_valid <= 1'b1;
                  if (sel_we) begin
                     ram_din <= {2'b00, sel_addr};
                     state   <= StWaddr;
                  end else begin
                     ram_din <= {2'b10, sel_addr};
                     state   <= StRaddr;
                  end
               end
            end
            StWaddr: begin
               ram_din <= {2'b01, wdata_q};
               state   <= StWdata;
            end
            StWdata: begin
               ram_rx_valid <= 1'b0;
               m0_ack       <= ~owner;
               m1_ack       <= owner;
               state        <= StAck;
            end
            StRaddr: begin
               ram_din <= {2'b11, {ADDR_WIDTH{1'b0}}};
               state   <= StRcmd;
            end
            StRcmd: begin
               ram_rx_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
               wait_cnt     <= '0;
`endif
               state        <= StRwait;
            end
            StRwait: begin
               if (ram_tx_valid) begin
                  if (owner) m1_rdata <= ram_dout;
                  else       m0_rdata <= ram_dout;
                  m0_ack <= ~owner;
                  m1_ack <= owner;
                  state  <= StAck;
               end
`ifdef ARB_TIMEOUT_EN
               else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  if (owner) m1_rdata <= {ADDR_WIDTH{1'b1}};
                  else       m0_rdata <= {ADDR_WIDTH{1'b1}};
                  m0_ack      <= ~owner;
                  m1_ack      <= owner;
                  timeout_err <= 1'b1;
                  state       <= StAck;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            StAck: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed self-checking bench for ram_access_arbiter with a small behavioural RAM model.
module tb_ram_access_arbiter;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic          m0_ack, m1_ack;
   logic [AW-1:0] m0_rdata, m1_rdata;
   logic [AW+1:0] ram_din;
   logic          ram_rx_valid;
   logic [AW-1:0] ram_dout;
   logic          ram_tx_valid;
   logic          busy, owner, timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ram_access_arbiter #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m0_req       (m0_req),
      .m0_we        (m0_we),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_ack       (m0_ack),
      .m0_rdata     (m0_rdata),
      .m1_req       (m1_req),
      .m1_we        (m1_we),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_ack       (m1_ack),
      .m1_rdata     (m1_rdata),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid),
      .busy         (busy),
      .owner        (owner),
      .timeout_err  (timeout_err)
   );

   // RAM model: answers a 2'b11 command one cycle later when enabled.
   logic [AW-1:0] mem [256];
   logic [AW-1:0] wa = '0;
   logic [AW-1:0] model_dout = '0;
   logic          model_tx = 1'b0;
   logic          model_en;
   logic          stray_tx;
   logic [AW-1:0] stray_dout;

   always @(posedge clk) begin
      model_tx <= 1'b0;
      if (ram_rx_valid) begin
         case (ram_din[AW+1:AW])
            2'b00: wa <= ram_din[AW-1:0];
            2'b01: mem[wa] <= ram_din[AW-1:0];
            2'b10: wa <= ram_din[AW-1:0];
            default: if (model_en) begin
               model_tx   <= 1'b1;
               model_dout <= mem[wa];
            end
         endcase
      end
   end

   assign ram_tx_valid = model_tx | stray_tx;
   assign ram_dout     = stray_tx ? stray_dout : model_dout;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output int port, output int overlap);
      port    = -1;
      overlap = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m0_ack && m1_ack) overlap = 1;
         if (m0_ack) begin port = 0; break; end
         if (m1_ack) begin port = 1; break; end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      int port, ovl, any_ovl, bad;
      int exp_rr [3] = '{0, 1, 0};

      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      model_en = 1'b1; stray_tx = 1'b0; stray_dout = '0;
      tick(); tick();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rx_valid", ram_rx_valid, 0);
      check_eq("rst_din", ram_din, 0);
      check_eq("rst_owner", owner, 0);
      check_eq("rst_acks", {m1_ack, m0_ack}, 0);
      check_eq("rst_rdata", {m1_rdata, m0_rdata}, 0);
      check_eq("rst_timeout", timeout_err, 0);
      rst = 1'b0;
      tick();

      // Port 0 write 0x12 <- 0xA5
      m0_we = 1; m0_addr = 8'h12; m0_wdata = 8'hA5; m0_req = 1;
      tick();
      check_eq("wr_cmd_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h012});
      check_eq("wr_owner", owner, 0);
      check_eq("wr_busy", busy, 1);
      tick();
      check_eq("wr_cmd_data", {ram_rx_valid, ram_din}, {1'b1, 10'h1A5});
      tick();
      check_eq("wr_ack", {m1_ack, m0_ack, ram_rx_valid}, 3'b010);
      m0_req = 0;
      tick();
      check_eq("wr_done", {m0_ack, busy}, 0);

      // Port 1 read 0x12
      m1_we = 0; m1_addr = 8'h12; m1_req = 1;
      tick();
      check_eq("rd_cmd_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h212});
      check_eq("rd_owner", owner, 1);
      tick();
      check_eq("rd_cmd_go", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
      tick();
      check_eq("rd_wait", {ram_rx_valid, busy, m1_ack, ram_din}, {1'b0, 1'b1, 1'b0, 10'h300});
      tick();
      check_eq("rd_ack", {m0_ack, m1_ack}, 2'b01);
      check_eq("rd_data", m1_rdata, 8'hA5);
      m1_req = 0;
      tick();

      // Simultaneous requests, three rounds
      m0_we = 1; m0_addr = 8'h20; m0_wdata = 8'h11;
      m1_we = 1; m1_addr = 8'h21; m1_wdata = 8'h22;
      m0_req = 1; m1_req = 1;
      any_ovl = 0;
      for (int r = 0; r < 3; r++) begin
         wait_ack(port, ovl);
         any_ovl |= ovl;
         check_eq("rr_grant", port, exp_rr[r]);
         check_eq("rr_owner", owner, exp_rr[r]);
         if (r < 2) begin
            if (port == 0) m0_req = 0; else m1_req = 0;
            tick();
            m0_req = 1; m1_req = 1;
         end else begin
            m0_req = 0; m1_req = 0;
            tick();
         end
      end
      check_eq("rr_overlap", any_ovl, 0);

      // Stray tx_valid in IDLE and WADDR
      stray_dout = 8'h77; stray_tx = 1;
      tick();
      stray_tx = 0;
      check_eq("stray_idle", {m1_ack, m0_ack, busy}, 0);
      check_eq("stray_idle_rd", {m1_rdata, m0_rdata}, {8'hA5, 8'h00});
      m0_we = 1; m0_addr = 8'h30; m0_wdata = 8'h44; m0_req = 1;
      tick();
      stray_tx = 1;
      tick();
      stray_tx = 0;
      check_eq("stray_waddr", {m1_ack, m0_ack}, 0);
      check_eq("stray_waddr_rd", {m1_rdata, m0_rdata}, {8'hA5, 8'h00});
      tick();
      check_eq("stray_wr_ack", m0_ack, 1);
      m0_req = 0;
      tick();

      // Reset during RWAIT
      model_en = 0;
      m0_we = 0; m0_addr = 8'h12; m0_req = 1;
      tick(); tick(); tick();
      check_eq("rw_state", {busy, ram_rx_valid}, 2'b10);
      rst = 1;
      #1;
      check_eq("rw_rst_out", {ram_rx_valid, busy, m1_ack, m0_ack, owner}, 0);
      check_eq("rw_rst_din", ram_din, 0);
      check_eq("rw_rst_rd", {m1_rdata, m0_rdata}, 0);
      m0_req = 0;
      tick();
      rst = 0;
      tick();
      stray_tx = 1;
      tick();
      stray_tx = 0;
      check_eq("rw_stray", {m1_ack, m0_ack, busy, m0_rdata}, 0);
      model_en = 1;
      m1_we = 0; m1_addr = 8'h12; m1_req = 1;
      tick(); tick(); tick(); tick();
      check_eq("rw_after_ack", {m0_ack, m1_ack}, 2'b01);
      check_eq("rw_after_rd", m1_rdata, 8'hA5);
      m1_req = 0;
      tick();

      // Unanswered read
      model_en = 0;
      m0_we = 0; m0_addr = 8'h12; m0_req = 1;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 6; i++) tick();
      check_eq("to_early", m0_ack, 0);
      tick();
      check_eq("to_ack", {m1_ack, m0_ack, timeout_err}, 3'b011);
      check_eq("to_rdata", m0_rdata, 8'hFF);
      m0_req = 0;
      tick();
      check_eq("to_done", {timeout_err, busy}, 0);
`else
      tick();
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!busy || m0_ack || m1_ack || timeout_err) bad++;
      end
      check_eq("hang_busy", bad, 0);
      rst = 1;
      m0_req = 0;
      tick();
      rst = 0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
